mc_fetch_datapath: RTL and testbench
====================================

# mc_fetch_datapath

Multicycle-processor fetch/holding-register block consuming the main controller's control word (IRWE, PCWE, Branch, PCSel, IDSel) and supplying the controller's opcode. Holds PC, instruction register (IR), memory data register (MDR), A/B operand registers and ALUOut, and drives the unified memory address. Sits between the main controller, unified memory, register file and ALU.

## Interface
- DW, 32, datapath width; 32 is the only supported value.
- RST_PC, 32'h0000_0000, PC value after reset; must be word-aligned.

- CLK  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- IRWE  in  1  IR write enable
- PCWE  in  1  unconditional PC write enable
- Branch  in  1  conditional PC write (with zero)
- PCSel  in  2  next-PC source select
- IDSel  in  1  memory address select: 0 = PC, 1 = ALUOut
- zero  in  1  ALU zero flag
- alu_result  in  DW  ALU result, combinational
- mem_rdata  in  DW  memory read data, asynchronous read
- rf_rd1, rf_rd2  in  DW  register-file read ports
- mem_addr  out  DW  memory address
- pc  out  DW  current PC
- instr  out  DW  IR contents
- op  out  6  instr[31:26], to controller
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- funct  out  6  instr[5:0]
- imm_sext  out  DW  sign-extended instr[15:0]
- imm_sext_sl2  out  DW  imm_sext << 2
- mdr, a_reg, b_reg, alu_out  out  DW  holding registers
- pc_misalign  out  1  sticky misaligned-PC-write flag
- cycle_cnt, instr_cnt  out  32 each  performance counters (see Configuration)

## Operation
- pc_en = PCWE | (Branch & zero). When both terms are true, one write occurs.
- Next-PC selection:
  - PCSel 00: alu_result (PC+4).
  - PCSel 01: alu_out (branch target registered in decode).
  - PCSel 10: {pc[31:28], instr[25:0], 2'b00}.
  - PCSel 11: no write, regardless of pc_en.
- Misalignment: a PC write whose selected value has bits [1:0] != 00 is blocked, and pc_misalign sets. pc_misalign clears only on rst.
- IR: loads mem_rdata when IRWE=1, otherwise holds. op, rs, rt, rd, funct and the immediates are combinational from IR.
- mdr, a_reg, b_reg, alu_out: load every cycle from mem_rdata, rf_rd1, rf_rd2 and alu_result respectively. No enable.
- mem_addr = IDSel ? alu_out : pc. A non-1 IDSel (including X from the controller) selects pc.
- Control inputs equal to X must not corrupt state. Treat X on IRWE, PCWE or Branch as 0.

## Timing
- Reset values: pc = RST_PC; instr, mdr, a_reg, b_reg, alu_out = 0; pc_misalign = 0; counters = 0. Consequently op = 000000 after reset.
- IRWE and PCWE high in the same cycle (fetch): IR captures the word at the old PC, and pc updates at the same edge.
- op reflects a new instruction one cycle after the IRWE cycle, which is when the controller's decode state samples it.
- Branch taken: pc updates at the edge ending the branch state. Not taken: pc holds.
- Jump target uses the already-incremented pc[31:28].
- rst asserted mid-instruction: every register returns to its reset value at that edge. No partial write completes.

## Configuration
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on every cycle with IRWE=1.
  - Both saturate at 32'hFFFF_FFFF.
- MC_PERF_CNT_EN undefined: counter logic is not built. cycle_cnt and instr_cnt remain as ports, tied to 0.

## Structure
- Package mc_pkg holds:
  - PCSel encodings: PC_SEL_ALU, PC_SEL_ALUOUT, PC_SEL_JUMP, PC_SEL_HOLD.
  - Opcode constants: OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010, OP_ADDI 001000.
  - DW.
- Sub-module mc_en_reg: parameterised-width register with synchronous reset value and enable. Used for PC, IR and the holding registers.

## Test plan
- Reset: rst high for 2 cycles with RST_PC=0 -> pc=0, instr=0, op=0, pc_misalign=0, mem_addr=0.
- Fetch: mem_rdata=32'h8C43_0004, alu_result=4, IRWE=PCWE=1, PCSel=00 for one cycle -> pc=4, op=100011, rt=3, imm_sext=4.
- Branch: alu_out=32'h40, PCSel=01, Branch=1; zero=0 -> pc unchanged; zero=1 -> pc=32'h40. With PCWE=1 also asserted -> exactly one write, pc=32'h40.
- Jump: pc=32'h1000_0008, instr=32'h0800_0010, PCSel=10, PCWE=1 -> pc=32'h1000_0040.
- Misalign: alu_result=32'h6, PCSel=00, PCWE=1 -> pc unchanged, pc_misalign=1. pc_misalign stays 1 after later aligned writes and clears on rst.
- Counters:
  - With MC_PERF_CNT_EN: 10 cycles after reset with 3 IRWE pulses -> cycle_cnt=10, instr_cnt=3. Preloading near 32'hFFFF_FFFF shows both hold at 32'hFFFF_FFFF.
  - Without MC_PERF_CNT_EN: both read 0.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants for the multicycle fetch datapath
// Purpose: datapath width, next-PC select encodings and opcode constants
//          used by mc_fetch_datapath and its controller.
package mc_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    PC_SEL_ALU    = 2'b00,  // alu_result (PC+4)
    PC_SEL_ALUOUT = 2'b01,  // branch target held in ALUOut
    PC_SEL_JUMP   = 2'b10,  // {pc[31:28], target, 00}
    PC_SEL_HOLD   = 2'b11   // never writes PC
  } pc_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

endpackage

// File: rtl/mc_en_reg.sv
// rtl/mc_en_reg.sv - enabled register with synchronous reset value
// Purpose: generic W-bit register; reset has priority over enable.
// Ports:
//   CLK    in   clock, rising edge
//   rst    in   synchronous active-high reset, loads RST_VAL
//   en_i   in   load enable
//   d_i    in   W  data to load
//   q_o    out  W  register contents
module mc_en_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge CLK) begin
    if (rst) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mc_fetch_datapath.sv
// rtl/mc_fetch_datapath.sv - multicycle fetch and holding-register datapath
// Purpose: holds PC, IR, MDR, A, B and ALUOut; selects the next PC and the
//          unified memory address; decodes instruction fields for the
//          controller. Optional macro MC_PERF_CNT_EN builds the saturating
//          cycle/instruction counters (ports tied to 0 otherwise).
// Ports:
//   CLK, rst                     clock, synchronous active-high reset
//   IRWE, PCWE, Branch           IR write, PC write, conditional PC write
//   PCSel[1:0], IDSel            next-PC source, memory address source
//   zero, alu_result             ALU flag and combinational result
//   mem_rdata, rf_rd1, rf_rd2    memory read data, register-file ports
//   mem_addr, pc, instr          memory address, PC, IR
//   op, rs, rt, rd, funct        IR fields
//   imm_sext, imm_sext_sl2       sign-extended immediate, and shifted by 2
//   mdr, a_reg, b_reg, alu_out   holding registers
//   pc_misalign                  sticky misaligned PC write flag
//   cycle_cnt, instr_cnt         performance counters
module mc_fetch_datapath
  import mc_pkg::*;
#(
  parameter int            DW     = mc_pkg::DW,
  parameter logic [DW-1:0] RST_PC = '0
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          IRWE,
  input  logic          PCWE,
  input  logic          Branch,
  input  logic [1:0]    PCSel,
  input  logic          IDSel,
  input  logic          zero,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] instr,
  output logic [5:0]    op,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [5:0]    funct,
  output logic [DW-1:0] imm_sext,
  output logic [DW-1:0] imm_sext_sl2,
  output logic [DW-1:0] mdr,
  output logic [DW-1:0] a_reg,
  output logic [DW-1:0] b_reg,
  output logic [DW-1:0] alu_out,
  output logic          pc_misalign,
  output logic [31:0]   cycle_cnt,
  output logic [31:0]   instr_cnt
);

  // Case equality so an unknown control bit reads as "not asserted".
  logic irwe_ok, pcwe_ok, branch_ok, idsel_alu;
  assign irwe_ok   = (IRWE   === 1'b1);
  assign pcwe_ok   = (PCWE   === 1'b1);
  assign branch_ok = (Branch === 1'b1);
  assign idsel_alu = (IDSel  === 1'b1);

  logic [DW-1:0] pc_q, instr_q, pc_d;
  logic          pc_wr_req, pc_we, pc_misalign_q;

  always_comb begin
    pc_d = alu_result;
    case (PCSel)
      PC_SEL_ALU:    pc_d = alu_result;
      PC_SEL_ALUOUT: pc_d = alu_out;
      PC_SEL_JUMP:   pc_d = {pc_q[31:28], instr_q[25:0], 2'b00};
      default:       pc_d = pc_q;
    endcase
  end

  // Both enables true still yields a single write of the selected value.
  assign pc_wr_req = (pcwe_ok | (branch_ok & zero)) & (PCSel != PC_SEL_HOLD);
  assign pc_we     = pc_wr_req & (pc_d[1:0] == 2'b00);

  mc_en_reg #(.W(DW), .RST_VAL(RST_PC)) u_pc (
    .CLK(CLK), .rst(rst), .en_i(pc_we), .d_i(pc_d), .q_o(pc_q)
  );

  mc_en_reg #(.W(DW)) u_ir (
    .CLK(CLK), .rst(rst), .en_i(irwe_ok), .d_i(mem_rdata), .q_o(instr_q)
  );

  mc_en_reg #(.W(DW)) u_mdr (
    .CLK(CLK), .rst(rst), .en_i(1'b1), .d_i(mem_rdata), .q_o(mdr)
  );

  mc_en_reg #(.W(DW)) u_a (
    .CLK(CLK), .rst(rst), .en_i(1'b1), .d_i(rf_rd1), .q_o(a_reg)
  );

  mc_en_reg #(.W(DW)) u_b (
    .CLK(CLK), .rst(rst), .en_i(1'b1), .d_i(rf_rd2), .q_o(b_reg)
  );

  mc_en_reg #(.W(DW)) u_aluout (
    .CLK(CLK), .rst(rst), .en_i(1'b1), .d_i(alu_result), .q_o(alu_out)
  );

  // Sticky: only rst clears it.
  always_ff @(posedge CLK) begin
    if (rst) begin
      pc_misalign_q <= 1'b0;
    end else if (pc_wr_req && (pc_d[1:0] != 2'b00)) begin
      pc_misalign_q <= 1'b1;
    end
  end

  assign pc           = pc_q;
  assign instr        = instr_q;
  assign pc_misalign  = pc_misalign_q;
  assign mem_addr     = idsel_alu ? alu_out : pc_q;
  assign op           = instr_q[31:26];
  assign rs           = instr_q[25:21];
  assign rt           = instr_q[20:16];
  assign rd           = instr_q[15:11];
  assign funct        = instr_q[5:0];
  assign imm_sext     = {{(DW-16){instr_q[15]}}, instr_q[15:0]};
  assign imm_sext_sl2 = {imm_sext[DW-3:0], 2'b00};

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (irwe_ok && (instr_cnt_q != 32'hFFFF_FFFF)) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_fetch_datapath.sv
// tb/tb_mc_fetch_datapath.sv - directed vector bench for mc_fetch_datapath
module tb_mc_fetch_datapath;

  logic        CLK = 1'b0;
  logic        rst, IRWE, PCWE, Branch, IDSel, zero;
  logic [1:0]  PCSel;
  logic [31:0] alu_result, mem_rdata, rf_rd1, rf_rd2;
  logic [31:0] mem_addr, pc, instr, imm_sext, imm_sext_sl2;
  logic [31:0] mdr, a_reg, b_reg, alu_out, cycle_cnt, instr_cnt;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic        pc_misalign;

  always #5 CLK = ~CLK;

  mc_fetch_datapath dut (
    .CLK(CLK), .rst(rst), .IRWE(IRWE), .PCWE(PCWE), .Branch(Branch),
    .PCSel(PCSel), .IDSel(IDSel), .zero(zero), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .mem_addr(mem_addr), .pc(pc), .instr(instr), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .funct(funct), .imm_sext(imm_sext), .imm_sext_sl2(imm_sext_sl2),
    .mdr(mdr), .a_reg(a_reg), .b_reg(b_reg), .alu_out(alu_out),
    .pc_misalign(pc_misalign), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  typedef struct {
    logic        rst, irwe, pcwe, br;
    logic [1:0]  pcsel;
    logic        idsel, zero;
    logic [31:0] alu_res, mem_rd;
    logic [31:0] e_pc, e_instr, e_alu_out, e_addr;
    logic        e_mis;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic ir, input logic pw, input logic b,
                              input logic [1:0] ps, input logic ids, input logic z,
                              input logic [31:0] ar, input logic [31:0] md,
                              input logic [31:0] epc, input logic [31:0] ein,
                              input logic [31:0] eao, input logic [31:0] ead, input logic em);
    vec_t v;
    v.rst = r; v.irwe = ir; v.pcwe = pw; v.br = b; v.pcsel = ps; v.idsel = ids; v.zero = z;
    v.alu_res = ar; v.mem_rd = md;
    v.e_pc = epc; v.e_instr = ein; v.e_alu_out = eao; v.e_addr = ead; v.e_mis = em;
    return v;
  endfunction

  task automatic drive(input logic r, input logic ir, input logic pw, input logic b,
                       input logic [1:0] ps, input logic ids, input logic z,
                       input logic [31:0] ar, input logic [31:0] md);
    rst = r; IRWE = ir; PCWE = pw; Branch = b; PCSel = ps; IDSel = ids; zero = z;
    alu_result = ar; mem_rdata = md;
    @(posedge CLK);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] e_mdr, e_a, e_b, e_imm;
  logic        ok;

  initial begin
    rst = 1'b1; IRWE = 0; PCWE = 0; Branch = 0; PCSel = 0; IDSel = 0; zero = 0;
    alu_result = 0; mem_rdata = 0; rf_rd1 = 0; rf_rd2 = 0;

    //            rst ir pw br ps    ids z  alu_res        mem_rd         e_pc           e_instr        e_alu_out      e_addr         mis
    vecs[0]  = mk(1, 0, 0, 0, 2'd0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0);
    vecs[1]  = mk(1, 0, 0, 0, 2'd0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0);
    vecs[2]  = mk(0, 1, 1, 0, 2'd0, 0, 0, 32'h4,         32'h8C43_0004, 32'h4,         32'h8C43_0004, 32'h4,         32'h4,         0);
    vecs[3]  = mk(0, 0, 0, 0, 2'd0, 1, 0, 32'h40,        32'h0,         32'h4,         32'h8C43_0004, 32'h40,        32'h40,        0);
    vecs[4]  = mk(0, 0, 0, 1, 2'd1, 0, 0, 32'h40,        32'h0,         32'h4,         32'h8C43_0004, 32'h40,        32'h4,         0);
    vecs[5]  = mk(0, 0, 0, 1, 2'd1, 0, 1, 32'h40,        32'h0,         32'h40,        32'h8C43_0004, 32'h40,        32'h40,        0);
    vecs[6]  = mk(0, 0, 0, 0, 2'd0, 0, 1, 32'h80,        32'h0,         32'h40,        32'h8C43_0004, 32'h80,        32'h40,        0);
    vecs[7]  = mk(0, 0, 1, 1, 2'd1, 0, 1, 32'h80,        32'h0,         32'h80,        32'h8C43_0004, 32'h80,        32'h80,        0);
    vecs[8]  = mk(0, 1, 1, 0, 2'd0, 0, 0, 32'h1000_0008, 32'h0800_0010, 32'h1000_0008, 32'h0800_0010, 32'h1000_0008, 32'h1000_0008, 0);
    vecs[9]  = mk(0, 0, 1, 0, 2'd2, 0, 0, 32'h0,         32'h0,         32'h1000_0040, 32'h0800_0010, 32'h0,         32'h1000_0040, 0);
    vecs[10] = mk(0, 0, 1, 0, 2'd0, 0, 0, 32'h6,         32'h0,         32'h1000_0040, 32'h0800_0010, 32'h6,         32'h1000_0040, 1);
    vecs[11] = mk(0, 0, 1, 0, 2'd0, 0, 0, 32'h8,         32'h0,         32'h8,         32'h0800_0010, 32'h8,         32'h8,         1);
    vecs[12] = mk(0, 0, 1, 1, 2'd3, 0, 1, 32'hC,         32'h0,         32'h8,         32'h0800_0010, 32'hC,         32'h8,         1);
    vecs[13] = mk(1, 1, 1, 0, 2'd0, 0, 0, 32'h100,       32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         32'h0,         0);
    vecs[14] = mk(0, 1, 1, 0, 2'd0, 1, 0, 32'h4,         32'h1000_FFFC, 32'h4,         32'h1000_FFFC, 32'h4,         32'h4,         0);

    for (int i = 0; i < NV; i++) begin
      rf_rd1 = 32'h0000_1000 + i;
      rf_rd2 = 32'h0000_2000 + i;
      drive(vecs[i].rst, vecs[i].irwe, vecs[i].pcwe, vecs[i].br, vecs[i].pcsel,
            vecs[i].idsel, vecs[i].zero, vecs[i].alu_res, vecs[i].mem_rd);
      e_mdr = vecs[i].rst ? 32'h0 : vecs[i].mem_rd;
      e_a   = vecs[i].rst ? 32'h0 : 32'h0000_1000 + i;
      e_b   = vecs[i].rst ? 32'h0 : 32'h0000_2000 + i;
      e_imm = {{16{vecs[i].e_instr[15]}}, vecs[i].e_instr[15:0]};
      ok = (pc === vecs[i].e_pc) && (instr === vecs[i].e_instr) &&
           (alu_out === vecs[i].e_alu_out) && (mem_addr === vecs[i].e_addr) &&
           (pc_misalign === vecs[i].e_mis) && (op === vecs[i].e_instr[31:26]) &&
           (rt === vecs[i].e_instr[20:16]) && (imm_sext === e_imm) &&
           (mdr === e_mdr) && (a_reg === e_a) && (b_reg === e_b);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL vec%0d: pc=%h/%h instr=%h/%h alu_out=%h/%h addr=%h/%h mis=%b/%b op=%h rt=%h imm=%h/%h mdr=%h/%h a=%h/%h b=%h/%h",
                 i, pc, vecs[i].e_pc, instr, vecs[i].e_instr, alu_out, vecs[i].e_alu_out,
                 mem_addr, vecs[i].e_addr, pc_misalign, vecs[i].e_mis, op, rt,
                 imm_sext, e_imm, mdr, e_mdr, a_reg, e_a, b_reg, e_b);
      end
    end

    check32("imm_sext_sl2_neg", imm_sext_sl2, 32'hFFFF_FFF0);
    check32("op_beq", {26'd0, op}, 32'h0000_0004);

    // Counter sequence: 2 reset cycles, then 10 cycles with 3 IRWE pulses.
    drive(1, 0, 0, 0, 2'd3, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 2'd3, 0, 0, 32'h0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      drive(0, (c == 1 || c == 4 || c == 7), 0, 0, 2'd3, 0, 0, 32'h0, 32'h0043_0820);
    end
    check32("rtype_rs", {27'd0, rs}, 32'd2);
    check32("rtype_rd", {27'd0, rd}, 32'd1);
    check32("rtype_funct", {26'd0, funct}, 32'h20);
    check32("rtype_sl2", imm_sext_sl2, 32'h0000_2080);
    check32("pc_hold_sel3", pc, 32'h0);
`ifdef MC_PERF_CNT_EN
    check32("cycle_cnt_10", cycle_cnt, 32'd10);
    check32("instr_cnt_3", instr_cnt, 32'd3);
    @(negedge CLK);
    dut.cycle_cnt_q = 32'hFFFF_FFFD;
    dut.instr_cnt_q = 32'hFFFF_FFFE;
    for (int c = 0; c < 4; c++) drive(0, 1, 0, 0, 2'd3, 0, 0, 32'h0, 32'h0);
    check32("cycle_cnt_sat", cycle_cnt, 32'hFFFF_FFFF);
    check32("instr_cnt_sat", instr_cnt, 32'hFFFF_FFFF);
`else
    check32("cycle_cnt_off", cycle_cnt, 32'd0);
    check32("instr_cnt_off", instr_cnt, 32'd0);
`endif

    // Misaligned write via ALUOut, then rst clears the sticky flag.
    drive(0, 0, 0, 0, 2'd0, 0, 0, 32'h0000_0022, 32'h0);
    drive(0, 0, 1, 0, 2'd1, 0, 0, 32'h0, 32'h0);
    check32("mis_aluout_pc", pc, 32'h0);
    check32("mis_aluout_flag", {31'd0, pc_misalign}, 32'd1);
    drive(1, 0, 0, 0, 2'd0, 0, 0, 32'h0, 32'h0);
    check32("mis_cleared", {31'd0, pc_misalign}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
